// File: rtl/velocidad_pulse_meter.sv
`timescale 1ns/1ps
// velocidad_pulse_meter
// Counts rising edges of an asynchronous speed-sensor pin over a fixed gate
// window of GATE_CYCLES clocks. The count is published as a raw velocity word
// for the downstream velocity debouncer. The output updates once per window
// and holds its value between updates.
//
// Ports:
//   clock            system clock; all logic runs on the rising edge
//   reset_n          asynchronous active-low reset
//   enable           synchronous run control; low = idle and the partial window is dropped
//   sensor_in        raw asynchronous sensor pin
//   velocidad        edge count of the last completed window, held between windows
//   velocidad_valid  one-cycle strobe when velocidad updates
//   overflow         the window behind velocidad lost edges to counter saturation
//
// Optional build macro:
//   VELOCIDAD_AVG_EN  when defined, each completed window outputs the mean of
//                     its count and the previous window's count. The first
//                     window after reset or re-enable outputs its raw count.
module velocidad_pulse_meter #(
  parameter int GATE_CYCLES = 1000000,
  parameter int VEL_W       = 24,
  parameter int GATE_W      = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sensor_in,
  output logic [VEL_W-1:0] velocidad,
  output logic             velocidad_valid,
  output logic             overflow
);

  typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_e;

  localparam logic [VEL_W-1:0]  CNT_MAX   = {VEL_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [VEL_W-1:0] sat_add(input logic [VEL_W-1:0] cnt,
                                               input logic             inc);
    if (inc && (cnt != CNT_MAX)) return cnt + VEL_W'(1);
    return cnt;
  endfunction

`ifdef VELOCIDAD_AVG_EN
  // Mean of two counts. The sum is one bit wider so it cannot wrap.
  function automatic logic [VEL_W-1:0] avg2(input logic [VEL_W-1:0] a,
                                            input logic [VEL_W-1:0] b);
    logic [VEL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[VEL_W:1];
  endfunction
`endif

  state_e            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [VEL_W-1:0]  pulse_cnt_q;
  logic              sat_q;
  logic [VEL_W-1:0]  velocidad_q;
  logic              valid_q;
  logic              overflow_q;
`ifdef VELOCIDAD_AVG_EN
  logic [VEL_W-1:0]  prev_q;
  logic              prev_ok_q;
`endif

  logic              pulse_edge;
  logic [VEL_W-1:0]  pulse_cnt_d;
  logic              sat_d;
  logic [VEL_W-1:0]  velocidad_d;

  always_comb begin
    pulse_edge  = s2_q & ~s3_q;
    pulse_cnt_d = sat_add(pulse_cnt_q, pulse_edge);
    // An edge arriving while the counter is already full is a lost count.
    sat_d       = sat_q | (pulse_edge & (pulse_cnt_q == CNT_MAX));
`ifdef VELOCIDAD_AVG_EN
    velocidad_d = prev_ok_q ? avg2(pulse_cnt_d, prev_q) : pulse_cnt_d;
`else
    velocidad_d = pulse_cnt_d;
`endif
  end

  // Two-flop synchronizer plus one history flop. These run even while idle,
  // so a level that is already high when a window starts is not seen as an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sensor_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gate_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      sat_q       <= 1'b0;
      velocidad_q <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef VELOCIDAD_AVG_EN
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gate_cnt_q  <= '0;
          pulse_cnt_q <= '0;
          sat_q       <= 1'b0;
`ifdef VELOCIDAD_AVG_EN
          prev_ok_q   <= 1'b0;
`endif
          if (enable) state_q <= GATE;
        end
        GATE: begin
          if (!enable) begin
            // Drop the partial window; the published result stays as it was.
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            sat_q       <= 1'b0;
          end else if (gate_cnt_q == GATE_LAST) begin
            // The edge on the final cycle belongs to the closing window.
            // The next window starts on the following cycle with no gap.
            velocidad_q <= velocidad_d;
            overflow_q  <= sat_d;
            valid_q     <= 1'b1;
            gate_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            sat_q       <= 1'b0;
`ifdef VELOCIDAD_AVG_EN
            prev_q      <= pulse_cnt_d;
            prev_ok_q   <= 1'b1;
`endif
          end else begin
            gate_cnt_q  <= gate_cnt_q + GATE_W'(1);
            pulse_cnt_q <= pulse_cnt_d;
            sat_q       <= sat_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign velocidad       = velocidad_q;
  assign velocidad_valid = valid_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_velocidad_pulse_meter.sv
`timescale 1ns/1ps
// Bench for velocidad_pulse_meter. Two instances share all inputs: a 24-bit
// instance and a 4-bit instance that saturates easily. Both run with
// GATE_CYCLES = 100. The reference model is event based. It records each
// sampled pin rise, delivers that rise two clocks later, and counts the rises
// that land inside each active window using an unbounded integer that is
// clamped only when the result is published.
module tb_velocidad_pulse_meter;

  localparam int G    = 100;
  localparam int MAXA = (1 << 24) - 1;
  localparam int MAXB = 15;
`ifdef VELOCIDAD_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sensor_in;
  logic [23:0] vel_a;
  logic        val_a, ovf_a;
  logic [3:0]  vel_b;
  logic        val_b, ovf_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  velocidad_pulse_meter #(.GATE_CYCLES(G), .VEL_W(24), .GATE_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sensor_in(sensor_in),
    .velocidad(vel_a), .velocidad_valid(val_a), .overflow(ovf_a));

  velocidad_pulse_meter #(.GATE_CYCLES(G), .VEL_W(4), .GATE_W(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sensor_in(sensor_in),
    .velocidad(vel_b), .velocidad_valid(val_b), .overflow(ovf_b));

  // ---------------- reference model ----------------
  logic        exp_valid;
  logic [23:0] exp_vel_a;
  logic [3:0]  exp_vel_b;
  logic        exp_ovf_a, exp_ovf_b;

  initial begin
    int unsigned rise_q[$];
    int unsigned pcount;
    logic last_pin;
    bit   m_active, prev_ok;
    int   m_pos, m_cnt, e, raw_a, raw_b, prev_a, prev_b;
    pcount = 0; last_pin = 1'b0; m_active = 0; prev_ok = 0;
    m_pos = 0; m_cnt = 0; prev_a = 0; prev_b = 0;
    exp_valid = 1'b0; exp_vel_a = '0; exp_vel_b = '0; exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        rise_q.delete(); last_pin = 1'b0; m_active = 0; prev_ok = 0;
        m_pos = 0; m_cnt = 0; prev_a = 0; prev_b = 0;
        exp_valid = 1'b0; exp_vel_a = '0; exp_vel_b = '0; exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
      end else begin
        pcount++;
        e = 0;
        while (rise_q.size() > 0 && rise_q[0] + 2 <= pcount) begin
          if (rise_q[0] + 2 == pcount) e = 1;
          void'(rise_q.pop_front());
        end
        if (sensor_in === 1'b1 && last_pin === 1'b0) rise_q.push_back(pcount);
        last_pin = sensor_in;
        exp_valid = 1'b0;
        if (!m_active) begin
          m_pos = 0; m_cnt = 0; prev_ok = 0;
          if (enable) m_active = 1;
        end else if (!enable) begin
          m_active = 0;
        end else begin
          m_cnt += e;
          m_pos++;
          if (m_pos == G) begin
            raw_a = (m_cnt > MAXA) ? MAXA : m_cnt;
            raw_b = (m_cnt > MAXB) ? MAXB : m_cnt;
            exp_ovf_a = (m_cnt > MAXA);
            exp_ovf_b = (m_cnt > MAXB);
            if (AVG && prev_ok) begin
              exp_vel_a = 24'((raw_a + prev_a) / 2);
              exp_vel_b = 4'((raw_b + prev_b) / 2);
            end else begin
              exp_vel_a = 24'(raw_a);
              exp_vel_b = 4'(raw_b);
            end
            prev_a = raw_a; prev_b = raw_b; prev_ok = 1;
            exp_valid = 1'b1;
            m_pos = 0; m_cnt = 0;
          end
        end
      end
    end
  end

  logic [31:0] dut_obs, mdl_obs;
  assign dut_obs = {val_a, vel_a, ovf_a, val_b, vel_b, ovf_b};
  assign mdl_obs = {exp_valid, exp_vel_a, exp_ovf_a, exp_valid, exp_vel_b, exp_ovf_b};

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic en, input logic s);
    @(negedge clock);
    enable = en;
    sensor_in = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; sensor_in = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({vel_a, val_a, ovf_a, vel_b, val_b, ovf_b} !== 32'd0) begin
      errors++; $display("FAIL reset_state got=%h want=0", {vel_a, val_a, ovf_a, vel_b, val_b, ovf_b});
    end
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0);
      checks++;
      if (dut_obs !== mdl_obs) begin
        errors++; $display("FAIL reset_idle k=%0d got=%h want=%h", k, dut_obs, mdl_obs);
      end
    end
  endtask

  task automatic test_counting;
    int n, last;
    n = 0; last = 0;
    idle(4);
    for (int k = 0; k <= 305; k++) begin
      drive(1'b1, ((k % 100) < 80) && ((k % 8) < 3));
      checks++;
      if (dut_obs !== mdl_obs) begin
        errors++; $display("FAIL counting_model k=%0d got=%h want=%h", k, dut_obs, mdl_obs);
      end
      if (val_a) begin
        checks++;
        if (vel_a !== 24'd10 || ovf_a !== 1'b0 || k !== 101 + 100 * n) begin
          errors++; $display("FAIL counting_strobe k=%0d vel=%0d ovf=%b want vel=10 ovf=0 at k=%0d", k, vel_a, ovf_a, 101 + 100 * n);
        end
        n++; last = k;
      end
    end
    checks++;
    if (n !== 3 || last !== 301) begin
      errors++; $display("FAIL counting_nstrobes got=%0d last=%0d want=3 last=301", n, last);
    end
  endtask

  task automatic test_static;
    int n;
    n = 0;
    idle(4);
    for (int k = 0; k <= 402; k++) begin
      drive(1'b1, k < 301);
      checks++;
      if (dut_obs !== mdl_obs) begin
        errors++; $display("FAIL static_model k=%0d got=%h want=%h", k, dut_obs, mdl_obs);
      end
      if (val_a) begin
        checks++;
        if (vel_a !== ((n == 0) ? 24'd1 : 24'd0) || ovf_a !== 1'b0) begin
          errors++; $display("FAIL static_window%0d got=%0d want=%0d", n, vel_a, (n == 0) ? 1 : 0);
        end
        n++;
      end
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL static_nstrobes got=%0d want=4", n);
    end
  endtask

  task automatic test_boundary;
    logic [23:0] want [3];
    int n;
    want[0] = 24'd1; want[1] = 24'd0; want[2] = AVG ? 24'd0 : 24'd1;
    n = 0;
    idle(4);
    for (int k = 0; k <= 305; k++) begin
      drive(1'b1, (k == 98) || (k == 99) || (k == 199) || (k == 200));
      checks++;
      if (dut_obs !== mdl_obs) begin
        errors++; $display("FAIL boundary_model k=%0d got=%h want=%h", k, dut_obs, mdl_obs);
      end
      if (val_a && n < 3) begin
        checks++;
        if (vel_a !== want[n]) begin
          errors++; $display("FAIL boundary_window%0d got=%0d want=%0d", n, vel_a, want[n]);
        end
        n++;
      end
    end
  endtask

  task automatic test_saturation;
    int n;
    n = 0;
    idle(4);
    for (int k = 0; k <= 205; k++) begin
      drive(1'b1, (k < 100) ? (k % 2 == 0) : (k < 140 && ((k - 100) % 8) < 3));
      checks++;
      if (dut_obs !== mdl_obs) begin
        errors++; $display("FAIL saturation_model k=%0d got=%h want=%h", k, dut_obs, mdl_obs);
      end
      if (val_b) begin
        checks++;
        if (n == 0 && {vel_b, ovf_b, vel_a, ovf_a} !== {4'd15, 1'b1, 24'd50, 1'b0}) begin
          errors++; $display("FAIL saturation_full got b=%0d/%b a=%0d/%b want b=15/1 a=50/0", vel_b, ovf_b, vel_a, ovf_a);
        end
        if (n == 1 && {vel_b, ovf_b, ovf_a} !== {(AVG ? 4'd10 : 4'd5), 1'b0, 1'b0}) begin
          errors++; $display("FAIL saturation_next got b=%0d/%b want b=%0d/0", vel_b, ovf_b, AVG ? 10 : 5);
        end
        n++;
      end
    end
  endtask

  task automatic test_enable_mid;
    logic [23:0] saved;
    int n;
    n = 0;
    idle(4);
    saved = vel_a;
    for (int k = 0; k <= 270; k++) begin
      if (k < 60)       drive(1'b1, k < 56 && (k % 8) < 3);
      else if (k < 165) drive(1'b0, 1'b0);
      else              drive(1'b1, (k - 165) < 32 && ((k - 165) % 8) < 3);
      checks++;
      if (dut_obs !== mdl_obs) begin
        errors++; $display("FAIL enable_mid_model k=%0d got=%h want=%h", k, dut_obs, mdl_obs);
      end
      if (k < 266) begin
        checks++;
        if (val_a !== 1'b0 || vel_a !== saved) begin
          errors++; $display("FAIL enable_mid_hold k=%0d valid=%b vel=%0d want valid=0 vel=%0d", k, val_a, vel_a, saved);
        end
      end
      if (val_a) begin
        checks++;
        if (k !== 266 || vel_a !== 24'd4) begin
          errors++; $display("FAIL enable_mid_restart k=%0d vel=%0d want k=266 vel=4", k, vel_a);
        end
        n++;
      end
    end
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL enable_mid_nstrobes got=%0d want=1", n);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    idle(4);
    for (int k = 0; k <= 40; k++) drive(1'b1, (k % 8) < 3);
    #2 reset_n = 1'b0; enable = 1'b0;
    #1;
    checks++;
    if ({vel_a, val_a, ovf_a, vel_b, val_b, ovf_b} !== 32'd0) begin
      errors++; $display("FAIL reset_mid_clear got=%h want=0", {vel_a, val_a, ovf_a, vel_b, val_b, ovf_b});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    for (int k = 0; k <= 205; k++) begin
      drive(1'b1, (k < 100) ? (k < 80 && (k % 8) < 3) : (((k - 100) % 5) < 2));
      checks++;
      if (dut_obs !== mdl_obs) begin
        errors++; $display("FAIL reset_mid_model k=%0d got=%h want=%h", k, dut_obs, mdl_obs);
      end
      if (val_a) begin
        checks++;
        if (vel_a !== ((n == 0) ? 24'd10 : (AVG ? 24'd15 : 24'd20))) begin
          errors++; $display("FAIL reset_mid_window%0d got=%0d want=%0d", n, vel_a, (n == 0) ? 10 : (AVG ? 15 : 20));
        end
        n++;
      end
    end
  endtask

  task automatic test_random;
    int   off, p, n;
    logic s;
    off = 0; p = 4; n = 0; s = 1'b0;
    idle(4);
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) p = 1 << $urandom_range(1, 3);
      if (off > 0) off--;
      else if ($urandom_range(0, 249) == 0) off = $urandom_range(1, 5);
      if ($urandom_range(0, p - 1) == 0) s = ~s;
      drive(off == 0, s);
      checks++;
      if (dut_obs !== mdl_obs) begin
        errors++; $display("FAIL random_model k=%0d got=%h want=%h", k, dut_obs, mdl_obs);
      end
      if (val_a) n++;
    end
    checks++;
    if (n < 5) begin
      errors++; $display("FAIL random_strobes got=%0d want>=5", n);
    end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_static();
    test_boundary();
    test_saturation();
    test_enable_mid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
